layer_forward: RTL and testbench

LAYER_FORWARD -- requirements
Module: layer_forward

---
 rtl/layer_forward_pkg.sv | 19 +
 rtl/mac_cell.sv | 72 +++++++
 rtl/layer_forward.sv | 134 +++++++++++++
 tb/tb_layer_forward.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/layer_forward_pkg.sv
// Shared definitions for the layer forward / backpropagation blocks.
//   layer_state_t : controller state encoding (IDLE, CALC, DONE)
//   acc_width()   : accumulator width that holds a full N-term dot product
//                   of signed weights and zero-extended activations
package layer_forward_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } layer_state_t;

  // The +1 covers zero-extending the activation into a signed operand.
  // The clog2 term covers the growth from summing n products.
  function automatic int acc_width(input int weight_w, input int act_w, input int n);
    return weight_w + act_w + 1 + $clog2(n);
  endfunction

endpackage

// File: rtl/mac_cell.sv
// Signed multiply-accumulate cell with synchronous clear and a saturating
// output stage.
//   clk, rst : clock, asynchronous active-low reset (clears the accumulator)
//   clr      : zero the accumulator on this edge
//   en       : add w*a to the accumulator on this edge
//   w        : signed weight
//   a        : unsigned activation (zero-extended before the multiply)
//   z        : (acc >>> FRACTION_WIDTH) saturated to NEURON_OUTPUT_WIDTH bits
//   sat      : high while z is clipped
module mac_cell
  import layer_forward_pkg::*;
#(
  parameter int WEIGHT_CELL_WIDTH   = 16,
  parameter int ACTIVATION_WIDTH    = 9,
  parameter int NEURON_OUTPUT_WIDTH = 10,
  parameter int FRACTION_WIDTH      = 0,
  parameter int ACC_W = acc_width(WEIGHT_CELL_WIDTH, ACTIVATION_WIDTH, 1)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  clr,
  input  logic                                  en,
  input  logic signed [WEIGHT_CELL_WIDTH-1:0]   w,
  input  logic        [ACTIVATION_WIDTH-1:0]    a,
  output logic signed [NEURON_OUTPUT_WIDTH-1:0] z,
  output logic                                  sat
);

  localparam int PROD_W = WEIGHT_CELL_WIDTH + ACTIVATION_WIDTH + 1;

  // Saturation bounds expressed at accumulator width.
  localparam logic signed [ACC_W-1:0] Z_MAX =
    {{(ACC_W-NEURON_OUTPUT_WIDTH+1){1'b0}}, {(NEURON_OUTPUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] Z_MIN =
    {{(ACC_W-NEURON_OUTPUT_WIDTH+1){1'b1}}, {(NEURON_OUTPUT_WIDTH-1){1'b0}}};

  function automatic logic signed [NEURON_OUTPUT_WIDTH-1:0] saturate(
    input logic signed [ACC_W-1:0] v);
    if (v > Z_MAX)      return Z_MAX[NEURON_OUTPUT_WIDTH-1:0];
    else if (v < Z_MIN) return Z_MIN[NEURON_OUTPUT_WIDTH-1:0];
    else                return v[NEURON_OUTPUT_WIDTH-1:0];
  endfunction

  function automatic logic clipped(input logic signed [ACC_W-1:0] v);
    return (v > Z_MAX) || (v < Z_MIN);
  endfunction

  logic signed [PROD_W-1:0] w_ext;
  logic signed [PROD_W-1:0] a_ext;
  logic signed [PROD_W-1:0] prod_p0;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  acc_p0;
  logic signed [ACC_W-1:0]  shifted_p1;

  assign w_ext    = PROD_W'(w);
  assign a_ext    = $signed(PROD_W'(a));
  assign prod_p0  = w_ext * a_ext;
  assign prod_ext = ACC_W'(prod_p0);

  // Stage p0: accumulator
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     acc_p0 <= '0;
    else if (clr) acc_p0 <= '0;
    else if (en)  acc_p0 <= acc_p0 + prod_ext;
  end

  // Stage p1: fraction removal and saturation (combinational from acc_p0)
  assign shifted_p1 = acc_p0 >>> FRACTION_WIDTH;
  assign z          = saturate(shifted_p1);
  assign sat        = clipped(shifted_p1);

endmodule

// File: rtl/layer_forward.sv
// Forward pass of one fully connected layer: z[i] = sum_j w[i][j] * a[j].
//   clk, rst         : clock, asynchronous active-low reset
//   w, w_valid/ready : N*N signed weights, cell (i*N+j) = input j -> neuron i
//   a, a_valid/ready : N unsigned activations
//   z, z_valid/ready : N saturated signed neuron sums
//   error            : some z cell of the presented result was clipped
// Weights and activations are captured independently (either order); once
// both are held the layer walks the N columns, one per clock, with all
// neurons accumulating in parallel, then presents the result until taken.
module layer_forward
  import layer_forward_pkg::*;
#(
  parameter int NEURON_NUM          = 5,
  parameter int NEURON_OUTPUT_WIDTH = 10,
  parameter int ACTIVATION_WIDTH    = 9,
  parameter int WEIGHT_CELL_WIDTH   = 16,
  parameter int FRACTION_WIDTH      = 0
) (
  input  logic                                               clk,
  input  logic                                               rst,
  input  logic [NEURON_NUM*NEURON_NUM*WEIGHT_CELL_WIDTH-1:0] w,
  input  logic                                               w_valid,
  output logic                                               w_ready,
  input  logic [NEURON_NUM*ACTIVATION_WIDTH-1:0]             a,
  input  logic                                               a_valid,
  output logic                                               a_ready,
  output logic [NEURON_NUM*NEURON_OUTPUT_WIDTH-1:0]          z,
  output logic                                               z_valid,
  input  logic                                               z_ready,
  output logic                                               error
);

  localparam int N     = NEURON_NUM;
  localparam int ACC_W = acc_width(WEIGHT_CELL_WIDTH, ACTIVATION_WIDTH, N);
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  layer_state_t state, state_nxt;
  logic             w_held, a_held;
  logic             w_fire, a_fire;
  logic             clr, en;
  logic [CNT_W-1:0] cnt;
  logic [N*N*WEIGHT_CELL_WIDTH-1:0] w_reg;
  logic [N*ACTIVATION_WIDTH-1:0]    a_reg;
  logic [ACTIVATION_WIDTH-1:0]      a_sel;
  logic [N-1:0]                     sat_vec;

  assign w_fire = w_valid && w_ready;
  assign a_fire = a_valid && a_ready;

  always_comb begin
    state_nxt = state;
    w_ready   = 1'b0;
    a_ready   = 1'b0;
    z_valid   = 1'b0;
    clr       = 1'b0;
    en        = 1'b0;
    case (state)
      IDLE: begin
        w_ready = !w_held;
        a_ready = !a_held;
        // An un-held input is always ready here, so valid alone means capture.
        if ((w_held || w_valid) && (a_held || a_valid)) begin
          state_nxt = CALC;
          clr       = 1'b1;
        end
      end
      CALC: begin
        en = 1'b1;
        if (cnt == LAST) state_nxt = DONE;
      end
      DONE: begin
        z_valid = 1'b1;
        if (z_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0: control state, held flags, column counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      w_held <= 1'b0;
      a_held <= 1'b0;
      cnt    <= '0;
    end else begin
      state <= state_nxt;
      if (state == DONE && z_ready) begin
        w_held <= 1'b0;
        a_held <= 1'b0;
      end else begin
        if (w_fire) w_held <= 1'b1;
        if (a_fire) a_held <= 1'b1;
      end
      if (clr)                    cnt <= '0;
      else if (en && cnt != LAST) cnt <= cnt + CNT_W'(1);
    end
  end

  // Operand capture; data registers carry no reset.
  always_ff @(posedge clk) begin
    if (w_fire) w_reg <= w;
    if (a_fire) a_reg <= a;
  end

  assign a_sel = a_reg[int'(cnt)*ACTIVATION_WIDTH +: ACTIVATION_WIDTH];

  // Stage p1: one MAC per neuron, all fed the same activation column
  for (genvar i = 0; i < N; i++) begin : g_neuron
    logic signed [WEIGHT_CELL_WIDTH-1:0] w_sel;
    assign w_sel = w_reg[(i*N + int'(cnt))*WEIGHT_CELL_WIDTH +: WEIGHT_CELL_WIDTH];

    mac_cell #(
      .WEIGHT_CELL_WIDTH  (WEIGHT_CELL_WIDTH),
      .ACTIVATION_WIDTH   (ACTIVATION_WIDTH),
      .NEURON_OUTPUT_WIDTH(NEURON_OUTPUT_WIDTH),
      .FRACTION_WIDTH     (FRACTION_WIDTH),
      .ACC_W              (ACC_W)
    ) u_mac (
      .clk (clk),
      .rst (rst),
      .clr (clr),
      .en  (en),
      .w   (w_sel),
      .a   (a_sel),
      .z   (z[i*NEURON_OUTPUT_WIDTH +: NEURON_OUTPUT_WIDTH]),
      .sat (sat_vec[i])
    );
  end

  assign error = (state == DONE) && (|sat_vec);

endmodule

// File: tb/tb_layer_forward.sv
module tb_layer_forward;

  localparam int N    = 2;
  localparam int ZW   = 10;
  localparam int AW   = 9;
  localparam int WW   = 16;
  localparam int FRAC = 0;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [N*N*WW-1:0]   w = '0;
  logic                w_valid = 1'b0;
  logic                w_ready;
  logic [N*AW-1:0]     a = '0;
  logic                a_valid = 1'b0;
  logic                a_ready;
  logic [N*ZW-1:0]     z;
  logic                z_valid;
  logic                z_ready = 1'b0;
  logic                error;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model state: operands last driven and the expected result.
  int     cur_w[4];
  int     cur_a[2];
  longint exp_z[2];
  bit     exp_err;
  bit     exp_pending = 1'b0;

  layer_forward #(
    .NEURON_NUM         (N),
    .NEURON_OUTPUT_WIDTH(ZW),
    .ACTIVATION_WIDTH   (AW),
    .WEIGHT_CELL_WIDTH  (WW),
    .FRACTION_WIDTH     (FRAC)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .w      (w),
    .w_valid(w_valid),
    .w_ready(w_ready),
    .a      (a),
    .a_valid(a_valid),
    .a_ready(a_ready),
    .z      (z),
    .z_valid(z_valid),
    .z_ready(z_ready),
    .error  (error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic longint zc(input int i);
    return longint'($signed(z[i*ZW +: ZW]));
  endfunction

  // Drive operand buses and remember them for the model.
  task automatic load(input int w00, input int w01, input int w10, input int w11,
                      input int a0, input int a1);
    cur_w[0] = w00; cur_w[1] = w01; cur_w[2] = w10; cur_w[3] = w11;
    cur_a[0] = a0;  cur_a[1] = a1;
    w = {16'(w11), 16'(w10), 16'(w01), 16'(w00)};
    a = {9'(a1), 9'(a0)};
  endtask

  // Dot product, fraction shift, clamp to the signed output range.
  task automatic set_expect();
    longint s;
    longint hi = (longint'(1) <<< (ZW-1)) - 1;
    longint lo = -(longint'(1) <<< (ZW-1));
    exp_err = 1'b0;
    for (int i = 0; i < N; i++) begin
      s = 0;
      for (int j = 0; j < N; j++) s += longint'(cur_w[i*N+j]) * longint'(cur_a[j]);
      s = s >>> FRAC;
      if (s > hi) begin s = hi; exp_err = 1'b1; end
      else if (s < lo) begin s = lo; exp_err = 1'b1; end
      exp_z[i] = s;
    end
    exp_pending = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_zvalid(input string name, input int want);
    int k = 0;
    while (!z_valid && k < 20) begin
      step();
      k++;
    end
    check(name, k, want);
  endtask

  task automatic handshake(input string name);
    z_ready = 1'b1;
    step();
    z_ready = 1'b0;
    exp_pending = 1'b0;
    check({name, "_zv_drop"}, z_valid, 0);
    check({name, "_err_drop"}, error, 0);
  endtask

  // Compare process: every falling edge, outputs against the model.
  always @(negedge clk) begin
    if (z_valid) begin
      check("zv_expected", exp_pending, 1);
      check("z0_model", zc(0), exp_z[0]);
      check("z1_model", zc(1), exp_z[1]);
      check("err_model", error, exp_err);
    end else begin
      check("err_outside_done", error, 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    #2 rst = 1'b0;
    @(negedge clk);
    check("rst_zv", z_valid, 0);
    check("rst_z", z, 0);
    check("rst_err", error, 0);
    step();
    rst = 1'b1;
    check("rst_wready", w_ready, 1);
    check("rst_aready", a_ready, 1);

    // Both operands on the same edge
    load(1, 2, 3, 4, 5, 6);
    w_valid = 1'b1; a_valid = 1'b1;
    set_expect();
    step();
    w_valid = 1'b0; a_valid = 1'b0;
    check("t1_wready_low", w_ready, 0);
    check("t1_aready_low", a_ready, 0);
    wait_zvalid("t1_latency", 2);
    check("t1_z0_lit", zc(0), 17);
    check("t1_z1_lit", zc(1), 39);
    check("t1_err_lit", error, 0);
    handshake("t1");
    check("t1_wready_back", w_ready, 1);

    // Weights first, activations three cycles later; bus changes ignored
    load(-1, 0, 0, -1, 100, 200);
    w_valid = 1'b1;
    step();
    w_valid = 1'b0;
    w = {4{16'h5A5A}};
    for (int c = 0; c < 3; c++) begin
      check("t2_wready_held", w_ready, 0);
      check("t2_aready_open", a_ready, 1);
      check("t2_zv_idle", z_valid, 0);
      step();
    end
    a_valid = 1'b1;
    set_expect();
    step();
    a_valid = 1'b0;
    a = '1;
    check("t2_aready_low", a_ready, 0);
    wait_zvalid("t2_latency", 2);
    check("t2_z0_lit", zc(0), -100);
    check("t2_z1_lit", zc(1), -200);
    handshake("t2");

    // Saturation in both directions
    load(32767, 32767, -32768, -32768, 511, 511);
    w_valid = 1'b1; a_valid = 1'b1;
    set_expect();
    step();
    w_valid = 1'b0; a_valid = 1'b0;
    wait_zvalid("t3_latency", 2);
    check("t3_z0_lit", zc(0), 511);
    check("t3_z1_lit", zc(1), -512);
    check("t3_err_lit", error, 1);
    handshake("t3");

    // Backpressure with new operands waiting
    load(2, 0, 0, 3, 10, 20);
    w_valid = 1'b1; a_valid = 1'b1;
    set_expect();
    step();
    w_valid = 1'b0; a_valid = 1'b0;
    wait_zvalid("t4_latency", 2);
    load(1, 1, 1, 1, 4, 5);
    w_valid = 1'b1; a_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      check("t4_zv_hold", z_valid, 1);
      check("t4_z0_hold", zc(0), 20);
      check("t4_z1_hold", zc(1), 60);
      check("t4_wready_bp", w_ready, 0);
      check("t4_aready_bp", a_ready, 0);
    end
    handshake("t4");
    check("t4_wready_release", w_ready, 1);
    check("t4_aready_release", a_ready, 1);
    set_expect();
    step();
    w_valid = 1'b0; a_valid = 1'b0;
    check("t4_new_taken", w_ready, 0);
    wait_zvalid("t4_new_latency", 2);
    check("t4_z0_new", zc(0), 9);
    check("t4_z1_new", zc(1), 9);
    handshake("t4b");

    // Reset during the first CALC cycle
    load(5, 5, 5, 5, 1, 1);
    w_valid = 1'b1; a_valid = 1'b1;
    step();
    w_valid = 1'b0; a_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("t5_zv_rst", z_valid, 0);
    check("t5_z_rst", z, 0);
    check("t5_err_rst", error, 0);
    step();
    step();
    rst = 1'b1;
    for (int c = 0; c < 6; c++) begin
      check("t5_no_result", z_valid, 0);
      check("t5_z_zero", z, 0);
      step();
    end
    load(1, 0, 0, 1, 7, 9);
    w_valid = 1'b1; a_valid = 1'b1;
    set_expect();
    step();
    w_valid = 1'b0; a_valid = 1'b0;
    wait_zvalid("t5_latency", 2);
    check("t5_z0_lit", zc(0), 7);
    check("t5_z1_lit", zc(1), 9);
    handshake("t5");

    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
